// File: rtl/data_mem_mc_if.sv
// -----------------------------------------------------------------------------
// data_mem_mc_if
// Request/response bundle between the MEM-stage stall logic (master) and the
// multi-cycle data memory (slave).
//   req_valid   master->slave  request present
//   req_ready   slave->master  memory can accept a request this cycle
//   req_we      master->slave  1 = store, 0 = load
//   req_addr    master->slave  byte address
//   req_wdata   master->slave  store data
//   req_funct3  master->slave  funct3 of the load/store instruction
//   resp_valid  slave->master  one-cycle pulse: access complete
//   resp_rdata  slave->master  extended load data, 0 for stores and errors
//   resp_err    slave->master  access faulted, qualified by resp_valid
// -----------------------------------------------------------------------------
interface data_mem_mc_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [2:0]               req_funct3;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_mc.sv
// -----------------------------------------------------------------------------
// data_mem_mc
// Multi-cycle byte-addressed data memory. One load/store is accepted per
// valid/ready handshake; the access (array write or read) happens LATENCY
// cycles after acceptance, at the same edge that raises resp_valid. Loads
// are sign/zero-extended; misaligned, out-of-range or unsupported accesses
// return resp_err=1 with zero data and leave the array untouched.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous active-high reset (memory contents are kept)
//   bus  data_mem_mc_if slave modport (request/response handshake)
// -----------------------------------------------------------------------------
module data_mem_mc #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int MEM_SIZE      = 131072,
  parameter int LATENCY       = 2,
  parameter     INIT_FILE     = "",
  parameter int INIT_BASE     = 'h10000
) (
  input logic         clk,
  input logic         rst,
  data_mem_mc_if.slave bus
);

  localparam int IDX_W  = $clog2(MEM_SIZE);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  logic [BYTE_WIDTH-1:0] mem_q [MEM_SIZE];

  // Access size in bytes for a funct3; 0 marks an unsupported encoding.
  function automatic logic [2:0] access_size(input logic we, input logic [2:0] f3);
    access_size = 3'd0;
    case (f3)
      3'b000:  access_size = 3'd1;
      3'b001:  access_size = 3'd2;
      3'b010:  access_size = 3'd4;
      3'b100:  access_size = we ? 3'd0 : 3'd1;
      3'b101:  access_size = we ? 3'd0 : 3'd2;
      default: access_size = 3'd0;
    endcase
  endfunction

  // funct3[2] selects zero extension (lbu/lhu); otherwise sign-extend.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] raw);
    logic sx;
    sx = ~f3[2];
    case (f3[1:0])
      2'b00:   load_extend = {{(DATA_WIDTH-BYTE_WIDTH){sx & raw[BYTE_WIDTH-1]}},
                              raw[BYTE_WIDTH-1:0]};
      2'b01:   load_extend = {{(DATA_WIDTH-2*BYTE_WIDTH){sx & raw[2*BYTE_WIDTH-1]}},
                              raw[2*BYTE_WIDTH-1:0]};
      default: load_extend = raw;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;

  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [2:0]               funct3_q;

  logic                     accept, do_access;
  logic                     acc_we, acc_err;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0]    acc_wdata, acc_raw;
  logic [2:0]               acc_f3, acc_size;
  logic [ADDRESS_WIDTH:0]   acc_last;
  logic [IDX_W-1:0]         acc_idx;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  assign accept = bus.req_valid & bus.req_ready;
  // With LATENCY=1 the access is performed at the accepting edge straight from
  // the bus; otherwise at the edge where the WAIT counter runs out.
  assign do_access = (LATENCY == 1) ? accept
                                    : (state_q == S_WAIT && cnt_q == CNT_W'(1));

  always_comb begin
    acc_we    = (LATENCY == 1) ? bus.req_we     : we_q;
    acc_addr  = (LATENCY == 1) ? bus.req_addr   : addr_q;
    acc_wdata = (LATENCY == 1) ? bus.req_wdata  : wdata_q;
    acc_f3    = (LATENCY == 1) ? bus.req_funct3 : funct3_q;
    acc_size  = access_size(acc_we, acc_f3);
    // Extra top bit keeps addr+size-1 from wrapping at the end of the space.
    acc_last  = {1'b0, acc_addr} + (ADDRESS_WIDTH+1)'(acc_size) - (ADDRESS_WIDTH+1)'(1);
    acc_err   = (acc_size == 3'd0)
              | ((acc_size == 3'd2) & acc_addr[0])
              | ((acc_size == 3'd4) & (|acc_addr[1:0]))
              | (acc_last >= (ADDRESS_WIDTH+1)'(MEM_SIZE));
    acc_idx   = acc_addr[IDX_W-1:0];
    acc_raw   = '0;
    for (int k = 0; k < NBYTES; k++) begin
      acc_raw[k*BYTE_WIDTH +: BYTE_WIDTH] = mem_q[acc_idx + IDX_W'(k)];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = do_access;
    resp_err_d   = do_access & acc_err;
    resp_rdata_d = '0;
    if (do_access && !acc_err && !acc_we) begin
      resp_rdata_d = load_extend(acc_f3, acc_raw);
    end
    case (state_q)
      S_IDLE: begin
        if (accept && LATENCY > 1) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
    end
  end

  // Store commit; a reset on the access edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && !acc_err && acc_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (3'(k) < acc_size) begin
          mem_q[acc_idx + IDX_W'(k)] <= acc_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_mc.sv
// -----------------------------------------------------------------------------
// tb_data_mem_mc
// Two instances: LATENCY=2 (dut2) and LATENCY=1 (dut1). Stimulus pushes the
// expected response (and its due cycle) into a per-instance queue; a negedge
// monitor pops and compares whenever resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_data_mem_mc;
  localparam int MEM_SIZE = 131072;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  data_mem_mc_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) if2 ();
  data_mem_mc_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) if1 ();

  data_mem_mc #(.MEM_SIZE(MEM_SIZE), .LATENCY(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));
  data_mem_mc #(.MEM_SIZE(MEM_SIZE), .LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;

  exp_t       q2[$];
  exp_t       q1[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference memory: byte map keyed by instance and address.
  function automatic void model(input int id, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] rd, output logic er);
    int     sz;
    int     key;
    longint val;
    sz = 0;
    if (we) begin
      if (f3 == 3'd0) sz = 1; else if (f3 == 3'd1) sz = 2; else if (f3 == 3'd2) sz = 4;
    end else begin
      if (f3 == 3'd0 || f3 == 3'd4) sz = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) sz = 2;
      else if (f3 == 3'd2) sz = 4;
    end
    rd = '0;
    er = (sz == 0);
    if (!er) er = ((longint'(a) % sz) != 0) || (longint'(a) + sz > MEM_SIZE);
    if (er) return;
    key = id * 'h100000 + int'(a);
    if (we) begin
      for (int i = 0; i < sz; i++) mdl[key + i] = wd[8*i +: 8];
    end else begin
      val = 0;
      for (int i = 0; i < sz; i++) val += longint'(mdl[key + i]) << (8 * i);
      if (!f3[2] && sz < 4 && val >= (longint'(1) << (8 * sz - 1)))
        val -= longint'(1) << (8 * sz);
      rd = val[31:0];
    end
  endfunction

  task automatic drive(input int id, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (id == 2) begin
      if2.req_valid = v; if2.req_we = we; if2.req_addr = a;
      if2.req_wdata = wd; if2.req_funct3 = f3;
    end else begin
      if1.req_valid = v; if1.req_we = we; if1.req_addr = a;
      if1.req_wdata = wd; if1.req_funct3 = f3;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 2) ? if2.req_ready : if1.req_ready;
  endfunction

  // mode 0: expect model result; 1: expect given constants; 2: expect nothing.
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input int mode,
                       input logic [31:0] erd, input logic eer);
    exp_t        x;
    logic [31:0] mrd;
    logic        mer;
    int          n;
    drive(id, 1'b1, we, a, wd, f3);
    n = 0;
    while (!rdy(id) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: req_ready low for %0d cycles, required high", id, n);
    end else if (mode != 2) begin
      model(id, we, a, wd, f3, mrd, mer);
      x.rd  = (mode == 1) ? erd : mrd;
      x.er  = (mode == 1) ? eer : mer;
      x.due = cyc + ((id == 2) ? 2 : 1);
      if (id == 2) q2.push_back(x); else q1.push_back(x);
    end
    @(negedge clk);
    drive(id, 1'b0, we, a, wd, f3);
  endtask

  task automatic monitor(input int id, input logic v, input logic [31:0] d, input logic e);
    exp_t x;
    int   sz;
    if (!v) begin
      chk($sformatf("idle_outputs_dut%0d", id), d | 32'(e), 32'd0);
    end else begin
      sz = (id == 2) ? q2.size() : q1.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp dut%0d: got rdata 0x%08h err %0d, required no response",
                 id, d, e);
      end else begin
        if (id == 2) x = q2.pop_front(); else x = q1.pop_front();
        chk($sformatf("rdata_dut%0d", id), d, x.rd);
        chk($sformatf("err_dut%0d", id), 32'(e), 32'(x.er));
        chk($sformatf("resp_cycle_dut%0d", id), 32'(cyc), 32'(x.due));
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(2, if2.resp_valid, if2.resp_rdata, if2.resp_err);
    monitor(1, if1.resp_valid, if1.resp_rdata, if1.resp_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    rst1 = 1'b1;
    rst2 = 1'b1;
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(negedge clk);
    chk("reset_ready_dut2", 32'(if2.req_ready), 32'd1);
    chk("reset_valid_dut2", 32'(if2.resp_valid), 32'd0);
    chk("reset_ready_dut1", 32'(if1.req_ready), 32'd1);
    chk("reset_valid_dut1", 32'(if1.resp_valid), 32'd0);
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Prefill every word that later loads may touch.
    for (int i = 0; i < 16; i++) issue(2, 1'b1, 32'h100 + 4*i, $urandom, 3'b010, 0, 0, 0);
    issue(2, 1'b1, MEM_SIZE - 8, $urandom, 3'b010, 0, 0, 0);
    issue(2, 1'b1, MEM_SIZE - 4, $urandom, 3'b010, 0, 0, 0);
    issue(2, 1'b1, 32'h200, 32'h11223344, 3'b010, 0, 0, 0);

    // Handshake timing at LATENCY=2.
    issue(2, 1'b0, 32'h100, 32'd0, 3'b010, 0, 0, 0);
    chk("t1_ready_wait", 32'(if2.req_ready), 32'd0);
    chk("t1_valid_wait", 32'(if2.resp_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_resp", 32'(if2.resp_valid), 32'd1);
    chk("t1_ready_resp", 32'(if2.req_ready), 32'd1);
    @(negedge clk);
    chk("t1_valid_after", 32'(if2.resp_valid), 32'd0);

    // Widths and extension.
    issue(2, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1, 32'h0, 1'b0);
    issue(2, 1'b0, 32'h100, 32'h0, 3'b010, 1, 32'hDEADBEEF, 1'b0);
    issue(2, 1'b0, 32'h100, 32'h0, 3'b100, 1, 32'h000000EF, 1'b0);
    issue(2, 1'b0, 32'h103, 32'h0, 3'b000, 1, 32'hFFFFFFDE, 1'b0);
    issue(2, 1'b0, 32'h102, 32'h0, 3'b001, 1, 32'hFFFFDEAD, 1'b0);
    issue(2, 1'b0, 32'h102, 32'h0, 3'b101, 1, 32'h0000DEAD, 1'b0);
    // Partial stores.
    issue(2, 1'b1, 32'h101, 32'h0000005A, 3'b000, 1, 32'h0, 1'b0);
    issue(2, 1'b0, 32'h100, 32'h0, 3'b010, 1, 32'hDEAD5AEF, 1'b0);
    issue(2, 1'b1, 32'h102, 32'h00001234, 3'b001, 1, 32'h0, 1'b0);
    issue(2, 1'b0, 32'h100, 32'h0, 3'b010, 1, 32'h12345AEF, 1'b0);
    // Faults.
    issue(2, 1'b0, 32'h102, 32'h0, 3'b010, 1, 32'h0, 1'b1);
    issue(2, 1'b1, 32'h103, 32'h0000FFFF, 3'b001, 1, 32'h0, 1'b1);
    issue(2, 1'b0, 32'h100, 32'h0, 3'b010, 1, 32'h12345AEF, 1'b0);
    issue(2, 1'b0, MEM_SIZE - 2, 32'h0, 3'b010, 1, 32'h0, 1'b1);
    issue(2, 1'b0, 32'h100, 32'h0, 3'b011, 1, 32'h0, 1'b1);
    issue(2, 1'b1, 32'h104, 32'h0, 3'b100, 1, 32'h0, 1'b1);
    issue(2, 1'b0, MEM_SIZE, 32'h0, 3'b100, 1, 32'h0, 1'b1);
    issue(2, 1'b0, MEM_SIZE - 1, 32'h0, 3'b100, 0, 0, 0);
    issue(2, 1'b0, MEM_SIZE - 4, 32'h0, 3'b010, 0, 0, 0);

    // Reset on the access edge cancels the store and its response.
    issue(2, 1'b1, 32'h200, 32'hCAFEF00D, 3'b010, 2, 0, 0);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("rst_mid_ready", 32'(if2.req_ready), 32'd1);
    issue(2, 1'b0, 32'h200, 32'h0, 3'b010, 1, 32'h11223344, 1'b0);

    // Randomized traffic on dut2.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) a = MEM_SIZE - 8 + $urandom_range(0, 15);
      else a = 32'h100 + $urandom_range(0, 63);
      issue(2, 1'(($urandom >> 3) & 1), a, $urandom, 3'($urandom_range(0, 7)), 0, 0, 0);
    end

    // LATENCY=1: continuous sw/lw stream.
    for (int i = 0; i < 4; i++) begin
      d = 32'hA5000000 | (i * 32'h00010203) | 32'h80;
      issue(1, 1'b1, 32'h40 + 4*i, d, 3'b010, 1, 32'h0, 1'b0);
      chk("b2b_ready_st", 32'(if1.req_ready), 32'd1);
      issue(1, 1'b0, 32'h40 + 4*i, 32'h0, 3'b010, 1, d, 1'b0);
      chk("b2b_ready_ld", 32'(if1.req_ready), 32'd1);
    end
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'h50 + 4*i, $urandom, 3'b010, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      issue(1, 1'(($urandom >> 5) & 1), 32'h40 + $urandom_range(0, 31), $urandom,
            3'($urandom_range(0, 7)), 0, 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("drain_q2", 32'(q2.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
